// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: 3-state fetch FSM, instruction register and opcode decode.
// Optional fetch timeout (16 WAIT cycles) is built only when FETCH_TIMEOUT_EN is defined.
module instr_fetch_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        instr_consume,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic        instr_valid,
  output logic [3:0]  instr,
  output logic        illegal,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sext,
  output logic [25:0] target,
  output logic        fetch_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        mem_rd_q, mem_rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] ir_q, ir_d;
  logic        instr_valid_q, instr_valid_d;
  logic        timeout_s;
  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [3:0]  instr_s;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] tmo_cnt_q, tmo_cnt_d;
  logic       fetch_err_q, fetch_err_d;

  assign timeout_s = (tmo_cnt_q == 4'd15);

  // WAIT-cycle counter; held at zero outside WAIT
  always_comb begin
    if (state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 4'd1;
    end else begin
      tmo_cnt_d = 4'd0;
    end
    fetch_err_d = (state_q == ST_WAIT) && !mem_ack && timeout_s;
  end

  // timeout counter and error pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q   <= 4'd0;
      fetch_err_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign timeout_s = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // fetch FSM next-state; an accepted ack wins over a simultaneous timeout
  always_comb begin
    state_d       = state_q;
    mem_rd_d      = mem_rd_q;
    mem_addr_d    = mem_addr_q;
    ir_d          = ir_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d    = ST_WAIT;
          mem_addr_d = pc;
          mem_rd_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d       = ST_VALID;
          ir_d          = mem_rdata;
          mem_rd_d      = 1'b0;
          instr_valid_d = 1'b1;
        end else if (timeout_s) begin
          state_d  = ST_IDLE;
          mem_rd_d = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_VALID: begin
        if (instr_consume) begin
          instr_valid_d = 1'b0;
          if (fetch_req) begin
            state_d    = ST_WAIT;
            mem_addr_d = pc;
            mem_rd_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_VALID;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        mem_rd_d      = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // FSM, address, strobe and instruction registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      ir_q          <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      ir_q          <= ir_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign op_s    = ir_q[31:26];
  assign funct_s = ir_q[5:0];

  // opcode/funct to FSM instruction code
  always_comb begin
    instr_s = 4'hF;
    case (op_s)
      6'h0E: instr_s = 4'd0;
      6'h23: instr_s = 4'd1;
      6'h2B: instr_s = 4'd2;
      6'h02: instr_s = 4'd6;
      6'h03: instr_s = 4'd7;
      6'h05: instr_s = 4'd9;
      6'h00: begin
        case (funct_s)
          6'h20:   instr_s = 4'd3;
          6'h22:   instr_s = 4'd4;
          6'h2A:   instr_s = 4'd5;
          6'h08:   instr_s = 4'd8;
          default: instr_s = 4'hF;
        endcase
      end
      default: instr_s = 4'hF;
    endcase
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_s;
  assign illegal     = instr_valid_q && (instr_s == 4'hF);
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign imm_sext    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign target      = ir_q[25:0];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed self-checking bench for instr_fetch_decode; timeout checks follow FETCH_TIMEOUT_EN.
module tb_instr_fetch_decode;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        instr_consume = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        instr_valid;
  logic [3:0]  instr;
  logic        illegal;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [25:0] target;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_decode dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc),
    .instr_consume(instr_consume), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .instr_valid(instr_valid),
    .instr(instr), .illegal(illegal), .rs(rs), .rt(rt), .rd(rd),
    .imm_sext(imm_sext), .target(target), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // IDLE -> WAIT -> VALID with ack on the first WAIT cycle, then decode checks
  task automatic fetch_decode(input string tag, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] exp_instr);
    fetch_req = 1'b1; pc = addr;
    tick();
    fetch_req = 1'b0;
    chk({tag, "_addr"}, mem_addr, addr);
    mem_ack = 1'b1; mem_rdata = data;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, {28'd0, instr}, {28'd0, exp_instr});
    chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, (exp_instr == 4'hF)});
  endtask

  task automatic consume();
    instr_consume = 1'b1;
    tick();
    instr_consume = 1'b0;
    chk("consume_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    int stuck_bad;
    // reset
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;

    // ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'h8C2A_0004;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_ack_ir", imm_sext, 32'd0);

    // LW at 0x40, 2-cycle latency
    fetch_req = 1'b1; pc = 32'h40;
    tick();
    fetch_req = 1'b0;
    chk("lw_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("lw_mem_addr", mem_addr, 32'h40);
    chk("lw_valid_early", {31'd0, instr_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h8C2A_0004;
    tick();
    mem_ack = 1'b0;
    chk("lw_valid", {31'd0, instr_valid}, 32'd1);
    chk("lw_mem_rd_clr", {31'd0, mem_rd}, 32'd0);
    chk("lw_instr", {28'd0, instr}, 32'd1);
    chk("lw_rs", {27'd0, rs}, 32'd1);
    chk("lw_rt", {27'd0, rt}, 32'd10);
    chk("lw_imm", imm_sext, 32'h0000_0004);

    // fetch_req and ack in VALID without consume are ignored
    fetch_req = 1'b1; pc = 32'h99; mem_ack = 1'b1; mem_rdata = 32'hFC00_0000;
    tick();
    fetch_req = 1'b0; mem_ack = 1'b0;
    chk("valid_hold", {31'd0, instr_valid}, 32'd1);
    chk("valid_hold_instr", {28'd0, instr}, 32'd1);
    chk("valid_hold_addr", mem_addr, 32'h40);
    chk("valid_hold_rd", {31'd0, mem_rd}, 32'd0);
    consume();
    chk("idle_mem_rd", {31'd0, mem_rd}, 32'd0);

    // consume in IDLE is ignored
    instr_consume = 1'b1;
    tick();
    instr_consume = 1'b0;
    chk("idle_consume", {31'd0, instr_valid}, 32'd0);

    fetch_decode("add", 32'h100, 32'h0043_0820, 4'd3);
    chk("add_rd", {27'd0, rd}, 32'd1);
    consume();
    fetch_decode("bne", 32'h104, 32'h1422_FFFE, 4'd9);
    chk("bne_imm", imm_sext, 32'hFFFF_FFFE);
    consume();
    fetch_decode("jr", 32'h108, 32'h03E0_0008, 4'd8);
    chk("jr_rs", {27'd0, rs}, 32'd31);
    consume();
    fetch_decode("xori", 32'h10C, 32'h3800_0000, 4'd0);
    consume();
    fetch_decode("sw", 32'h110, 32'hAC00_0000, 4'd2);
    consume();
    fetch_decode("j", 32'h114, 32'h0800_0010, 4'd6);
    chk("j_target", {6'd0, target}, 32'h0000_0010);
    consume();
    fetch_decode("jal", 32'h118, 32'h0C00_0000, 4'd7);
    consume();
    fetch_decode("sub", 32'h11C, 32'h0000_0022, 4'd4);
    consume();
    fetch_decode("slt", 32'h120, 32'h0000_002A, 4'd5);
    consume();
    fetch_decode("badfn", 32'h124, 32'h0000_0021, 4'hF);
    consume();
    fetch_decode("ill", 32'h128, 32'hFC00_0000, 4'hF);
    consume();
    chk("ill_after_consume", {31'd0, illegal}, 32'd0);

    // back-to-back: consume + fetch_req in VALID
    fetch_decode("b2b", 32'h40, 32'h8C2A_0004, 4'd1);
    instr_consume = 1'b1; fetch_req = 1'b1; pc = 32'h44;
    tick();
    instr_consume = 1'b0; fetch_req = 1'b0;
    chk("b2b_valid", {31'd0, instr_valid}, 32'd0);
    chk("b2b_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("b2b_addr", mem_addr, 32'h44);
    // fetch_req in WAIT ignored; WAIT holds strobe and address
    fetch_req = 1'b1; pc = 32'h88;
    tick();
    fetch_req = 1'b0;
    tick();
    chk("wait_addr", mem_addr, 32'h44);
    chk("wait_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("wait_valid", {31'd0, instr_valid}, 32'd0);

    // reset in WAIT aborts, late ack ignored, IR cleared
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h8C2A_0004;
    tick();
    mem_ack = 1'b0;
    chk("abort_mem_rd2", {31'd0, mem_rd}, 32'd0);
    chk("abort_valid", {31'd0, instr_valid}, 32'd0);
    chk("abort_ir_imm", imm_sext, 32'd0);
    chk("abort_ir_instr", {28'd0, instr}, 32'h0000_000F);
    chk("abort_ir_rs", {27'd0, rs}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    // no ack: error after 16 WAIT cycles
    fetch_req = 1'b1; pc = 32'h200;
    tick();
    fetch_req = 1'b0;
    stuck_bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (!mem_rd || fetch_err) stuck_bad++;
      tick();
    end
    if (!mem_rd || fetch_err) stuck_bad++;
    chk("tmo_wait_cycles", stuck_bad, 32'd0);
    tick();
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_mem_rd", {31'd0, mem_rd}, 32'd0);
    tick();
    chk("tmo_err_pulse", {31'd0, fetch_err}, 32'd0);
    chk("tmo_idle_rd", {31'd0, mem_rd}, 32'd0);
    // ack on the 16th cycle wins
    fetch_req = 1'b1; pc = 32'h204;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    mem_ack = 1'b1; mem_rdata = 32'h0043_0820;
    tick();
    mem_ack = 1'b0;
    chk("tmo_ack_err", {31'd0, fetch_err}, 32'd0);
    chk("tmo_ack_valid", {31'd0, instr_valid}, 32'd1);
    chk("tmo_ack_instr", {28'd0, instr}, 32'd3);
    consume();
`else
    // no ack: WAIT persists indefinitely
    fetch_req = 1'b1; pc = 32'h200;
    tick();
    fetch_req = 1'b0;
    stuck_bad = 0;
    for (int i = 0; i < 110; i++) begin
      if (!mem_rd || fetch_err || instr_valid) stuck_bad++;
      tick();
    end
    chk("no_tmo_stuck", stuck_bad, 32'd0);
    chk("no_tmo_addr", mem_addr, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'h03E0_0008;
    tick();
    mem_ack = 1'b0;
    chk("no_tmo_late_ack", {28'd0, instr}, 32'd8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
